// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Round-robin tie-break is selected by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int MEM_ARB_AW = 12;
    localparam int MEM_ARB_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two memory ports.
// MEM_ARB_RR_EN: round-robin tie-break; otherwise data port wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    assign grant_valid_o = req0_i | req1_i;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_id_o = PORT_IF;
        if (req0_i && req1_i) begin
            grant_id_o = ~last_grant_i;
        end else if (req1_i) begin
            grant_id_o = PORT_DATA;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign grant_id_o = req1_i ? PORT_DATA : PORT_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between fetch (port 0) and data (port 1) ports.
// Define MEM_ARB_RR_EN for round-robin ties (adds a last_grant flop).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = MEM_ARB_AW,
    parameter int DW = MEM_ARB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_e        state_q, state_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic last_grant;
    logic grant_valid;
    logic grant_id;

    mem_arb_pick u_pick (
        .req0_i        (p0_req),
        .req1_i        (p1_req),
        .last_grant_i  (last_grant),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_DATA;
        end else if (state_q == ST_IDLE && grant_valid) begin
            last_grant_q <= grant_id;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = PORT_DATA;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            win_q    <= PORT_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes and acks decode from state alone, so reset kills them at once.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_ACCESS;
                    win_d   = grant_id;
                    if (grant_id == PORT_DATA) begin
                        we_d    = p1_we;
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                    end else begin
                        we_d    = p0_we;
                        addr_d  = p0_addr;
                        wdata_d = p0_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                mem_read  = ~we_q;
                mem_write = we_q;
                state_d   = ST_RESP;
                if (!we_q) begin
                    if (win_q == PORT_DATA) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                p0_ack  = (win_q == PORT_IF);
                p1_ack  = (win_q == PORT_DATA);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a transaction-level model.
// Build with or without MEM_ARB_RR_EN; expectations follow the same macro.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_rdata  (p1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory seen by the DUT, and an independent copy owned by the model.
    logic [DW-1:0] tb_mem  [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: a granted transaction is a record stamped with its grant cycle;
    // outputs follow from how many cycles have elapsed since that grant.
    int            cyc = 0;
    bit            m_act = 1'b0;
    int            m_g = 0;
    bit            m_id = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
    bit            m_lg = 1'b1;

    task automatic model_reset();
        m_act = 1'b0;
        m_rd0 = '0;
        m_rd1 = '0;
        m_lg  = 1'b1;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else if (!m_act) begin
            if (p0_req || p1_req) begin
                m_act = 1'b1;
                m_g   = cyc;
                if (p0_req && p1_req) m_id = RR ? !m_lg : 1'b1;
                else m_id = p1_req;
                m_lg   = m_id;
                m_we   = m_id ? p1_we : p0_we;
                m_addr = m_id ? p1_addr : p0_addr;
                m_wd   = m_id ? p1_wdata : p0_wdata;
            end
        end else if (cyc == m_g + 1) begin
            if (m_we) ref_mem[m_addr] = m_wd;
            else if (m_id) m_rd1 = ref_mem[m_addr];
            else m_rd0 = ref_mem[m_addr];
        end else if (cyc == m_g + 2) begin
            m_act = 1'b0;
        end
        cyc++;
    end

    bit e_acc, e_rsp;

    always @(negedge clk) begin
        e_acc = m_act && (cyc == m_g + 1);
        e_rsp = m_act && (cyc == m_g + 2);
        chk("busy", busy, m_act);
        chk("mem_read", mem_read, e_acc && !m_we);
        chk("mem_write", mem_write, e_acc && m_we);
        chk("p0_ack", p0_ack, e_rsp && !m_id);
        chk("p1_ack", p1_ack, e_rsp && m_id);
        chk("p0_rdata", p0_rdata, m_rd0);
        chk("p1_rdata", p1_rdata, m_rd1);
        if (e_acc) chk("mem_addr", mem_addr, m_addr);
        if (e_acc && m_we) chk("mem_wdata", mem_wdata, m_wd);
        if (!rst_n) begin
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1);
    end

    int exp_c [5] = '{2, 5, 8, 11, 14};
    bit exp_id [5];
    int got_c [5];
    bit got_id [5];
    int n_ack;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = 16'(i * 3);
            ref_mem[i] = 16'(i * 3);
        end
        tb_mem[5] = 16'h1234;    ref_mem[5] = 16'h1234;
        tb_mem[3] = 16'hA5A5;    ref_mem[3] = 16'hA5A5;
        tb_mem[16] = 16'h0F0F;   ref_mem[16] = 16'h0F0F;
        if (RR) exp_id = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        else exp_id = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset held with random request traffic
        for (int i = 0; i < 4; i++) begin
            tick();
            p0_req = 1'($urandom);
            p1_req = 1'($urandom);
            p0_we = 1'($urandom);
            p1_we = 1'($urandom);
            p0_addr = 12'($urandom);
            p1_addr = 12'($urandom);
        end
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_acks", {p0_ack, p1_ack}, 0);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        rst_n = 1'b1;
        tick();
        tick();

        // Single read by port 0
        p0_req = 1; p0_we = 0; p0_addr = 12'h005;
        tick();
        chk("rd_mem_read", mem_read, 1);
        chk("rd_mem_addr", mem_addr, 12'h005);
        tick();
        chk("rd_p0_ack", p0_ack, 1);
        chk("rd_p0_rdata", p0_rdata, 16'h1234);
        chk("rd_p1_ack", p1_ack, 0);
        p0_req = 0;
        tick();

        // Port 1 write, then immediate back-to-back read of the same word
        p1_req = 1; p1_we = 1; p1_addr = 12'h7FF; p1_wdata = 16'hBEEF;
        tick();
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_read", mem_read, 0);
        chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
        tick();
        chk("wr_resp_mem_write", mem_write, 0);
        chk("wr_p1_ack", p1_ack, 1);
        p1_we = 0;
        tick();
        tick();
        tick();
        chk("rb_p1_ack", p1_ack, 1);
        chk("rb_p1_rdata", p1_rdata, 16'hBEEF);
        p1_req = 0;
        tick();

        // Request dropped during ACCESS still completes
        p0_req = 1; p0_we = 0; p0_addr = 12'h003;
        tick();
        p0_req = 0; p0_addr = 12'h005;
        tick();
        chk("drop_p0_ack", p0_ack, 1);
        chk("drop_p0_rdata", p0_rdata, 16'hA5A5);
        tick();
        chk("drop_idle1", busy, 0);
        tick();
        chk("drop_idle2", busy, 0);

        // Both ports request from reset
        rst_n = 0;
        p0_req = 1; p0_we = 0; p0_addr = 12'h005;
        p1_req = 1; p1_we = 0; p1_addr = 12'h7FF;
        tick();
        rst_n = 1;
        n_ack = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if ((p0_ack || p1_ack) && n_ack < 5) begin
                got_c[n_ack] = i;
                got_id[n_ack] = p1_ack;
                n_ack++;
            end
            if (i == 11) p1_req = 0;
            if (i == 14) p0_req = 0;
        end
        chk("tie_ack_count", n_ack, 5);
        for (int k = 0; k < n_ack; k++) begin
            chk($sformatf("tie_cycle%0d", k), got_c[k], exp_c[k]);
            chk($sformatf("tie_port%0d", k), got_id[k], exp_id[k]);
        end
        tick();
        tick();

        // Reset asserted during a write ACCESS
        p0_req = 1; p0_we = 1; p0_addr = 12'h010; p0_wdata = 16'h1111;
        tick();
        chk("rw_mem_write", mem_write, 1);
        rst_n = 0;
        p0_req = 0;
        #1;
        chk("rw_mem_write_drop", mem_write, 0);
        chk("rw_busy", busy, 0);
        chk("rw_ack", p0_ack, 0);
        tick();
        chk("rw_mem_kept", tb_mem[16], 16'h0F0F);
        chk("rw_ack_after", p0_ack, 0);
        rst_n = 1;
        tick();
        tick();
        chk("rw_mem_final", tb_mem[16], 16'h0F0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 12-bit-address, 16-bit-data unified memory between two requesters in the multi-cycle CPU: port 0 = instruction fetch, port 1 = data load/store.
- Sequences each access as a fixed 3-state transaction.
- Drives the memory's mem_read, mem_write, addr and write_data.
- Returns read data to the winning port with a one-cycle ack pulse.

Parameters:
- AW, 12, address width (memory depth 2^AW words)
- DW, 16, data word width

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- p0_req  in  1  port 0 request; held until p0_ack
- p0_we  in  1  port 0 write enable (0 = read)
- p0_addr  in  AW  port 0 word address
- p0_wdata  in  DW  port 0 write data
- p0_ack  out  1  port 0 transaction complete, one-cycle pulse
- p0_rdata  out  DW  port 0 read data, valid when p0_ack=1
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (combinational, arrives less than 1 cycle after mem_read/mem_addr)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - p0_ack=p1_ack=0, p0_rdata=p1_rdata=0
  - mem_read=mem_write=0, mem_addr=0, mem_wdata=0, busy=0
  - last_grant=1, so port 0 wins the first tie
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise pick a winner per the arbitration rule.
  - Register winner id, we, addr and wdata into the transaction registers; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata come from the transaction registers.
  - mem_read = ~we, mem_write = we; both are decoded from state and are 0 in every other state.
  - At the closing posedge:
    - Read: latch mem_rdata into the winner's rdata register.
    - Write: memory commits on the same edge.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Winner's ack=1; the other port's ack=0.
  - rdata holds the captured value; after a write, rdata is unchanged.
  - Then go to IDLE.
- Latency: req first sampled high in IDLE at cycle N; ack at cycle N+2; next grant possible at N+3. Throughput is 1 access per 3 cycles.
- Requests are sampled only in IDLE.
  - The transaction registers decouple the port: a req/addr change during ACCESS/RESP does not affect the access in flight.
  - The ack is still issued even if req drops early.
- Requester rule: drop req, or present a new request, on the edge after ack. A req still high in the following IDLE is served as a new transaction.
- Simultaneous reqs: resolved per the arbitration rule; the loser waits with req held and no ack.
- Address and data pass through unmodified; no wrap or arithmetic.
- Reset mid-transaction: immediate return to IDLE; mem_write drops asynchronously. A write in ACCESS whose posedge has not occurred is abandoned; no ack is issued.

Optional Feature:
- Macro: MEM_ARB_RR_EN
- Defined: round-robin. On a tie, the port not equal to last_grant wins. last_grant updates on every grant.
- Undefined: fixed priority, port 1 (data) always wins ties. last_grant is absent and no extra flops are built.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - AW/DW defaults
  - port id constants PORT_IF=1'b0, PORT_DATA=1'b1
- One sub-module: mem_arb_pick.
  - Combinational winner select.
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_id.
  - Contains the MEM_ARB_RR_EN conditional, keeping the FSM in mem_port_arbiter feature-independent.

Test Plan:
- Reset: hold rst_n=0 with random reqs -> all outputs 0, busy=0. Assert rst_n=0 during an ACCESS write to 0x010 -> mem_write falls immediately, no ack, mem[0x010] unchanged.
- Single read: preload mem[0x005]=16'h1234; p0 reads 0x005 at cycle N -> mem_read=1 and mem_addr=0x005 at N+1; p0_ack=1 with p0_rdata=16'h1234 at N+2; p1_ack stays 0.
- Write then read: p1 writes 16'hBEEF to 0x7FF -> mem_write=1 only in the ACCESS cycle, p1_ack at N+2. Then p1 reads 0x7FF -> p1_rdata=16'hBEEF.
- Tie, MEM_ARB_RR_EN defined: p0 and p1 both hold req from reset -> grant order p0, p1, p0, p1. Acks at cycles 2, 5, 8, 11 after first sample.
- Tie, MEM_ARB_RR_EN undefined: same stimulus -> p1 served every transaction while its req stays high; p0 served only after p1 drops req.
- Early req drop: p0 requests a read of 0x003, then drops req in the ACCESS cycle -> p0_ack still pulses at N+2 with mem[0x003]; the next IDLE stays idle.
